// File: rtl/spi_frame_sequencer_pkg.sv
// Shared types and defaults for the SPI frame sequencer.
package spi_frame_sequencer_pkg;

    localparam int unsigned DefAddrWidth = 10;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefLenWidth  = 10;
    localparam int unsigned DefHoldEdges = 2;

    // StZero is the single busy cycle of a zero-length request.
    typedef enum logic [2:0] {
        StIdle,
        StZero,
        StFetch,
        StWaitLoad,
        StShift,
        StHold,
        StDone
    } state_e;

    // Counter width able to hold 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_frame_sequencer_sclk_cnt.sv
// Small strobe counter: synchronous clear, count enable, terminal flag at last_i.
module spi_frame_sequencer_sclk_cnt #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] last_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/spi_frame_sequencer.sv
// Walks a block of display memory and feeds the SPI shift register word by word,
// driving chip-select and data/command, paced by serial-clock edge strobes.
module spi_frame_sequencer
    import spi_frame_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LEN_WIDTH  = DefLenWidth,
    parameter int unsigned HOLD_EDGES = DefHoldEdges
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [LEN_WIDTH-1:0]  xferLen,
    input  logic                  sclkPosEdge,
    input  logic                  sclkNegEdge,
    input  logic [DATA_WIDTH:0]   memData,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  parallelLoad,
    output logic [DATA_WIDTH-1:0] parallelDataOut,
    output logic                  cs,
    output logic                  dc,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DcBit = DATA_WIDTH;
    localparam int unsigned BitW  = cnt_width(DATA_WIDTH);
    localparam int unsigned HoldW = cnt_width(HOLD_EDGES);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_EDGES - 1);

    state_e                state_d, state_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [LEN_WIDTH-1:0]  len_d, len_q;
    logic [DATA_WIDTH:0]   next_word_d, next_word_q;
    logic                  req_d, req_q;
    logic                  cap_d, cap_q;
    logic                  cs_d, cs_q;
    logic                  dc_d, dc_q;

    logic                  bit_tc, hold_tc;
    logic                  last_bit, load, bit_en, hold_en;
    logic [DATA_WIDTH:0]   word_src;

    // Read data arrives the cycle after the address register changes (req_q), and is
    // on memData the cycle after that (cap_q); a load in that cycle takes it directly.
    assign word_src = cap_q ? memData : next_word_q;

    assign last_bit = (state_q == StShift) && sclkNegEdge && bit_tc;
    assign load     = sclkNegEdge &&
                      ((state_q == StWaitLoad) || (last_bit && (len_q != '0)));
    assign bit_en   = (state_q == StShift) && sclkNegEdge && !bit_tc;
    assign hold_en  = (state_q == StHold) && sclkPosEdge;

    spi_frame_sequencer_sclk_cnt #(
        .Width (BitW)
    ) u_bit_cnt (
        .clk_i  (clk),
        .rst_ni (resetN),
        .clr_i  (load),
        .en_i   (bit_en),
        .last_i (BitLast),
        .tc_o   (bit_tc)
    );

    spi_frame_sequencer_sclk_cnt #(
        .Width (HoldW)
    ) u_hold_cnt (
        .clk_i  (clk),
        .rst_ni (resetN),
        .clr_i  (load),
        .en_i   (hold_en),
        .last_i (HoldLast),
        .tc_o   (hold_tc)
    );

    // Next-state: FSM, address/length bookkeeping and prefetch capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        next_word_d = next_word_q;
        req_d       = 1'b0;
        cap_d       = req_q;
        cs_d        = cs_q;
        dc_d        = dc_q;

        if (cap_q) begin
            next_word_d = memData;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (xferLen != '0) begin
                        addr_d  = baseAddr;
                        len_d   = xferLen;
                        req_d   = 1'b1;
                        cs_d    = 1'b0;
                        state_d = StFetch;
                    end else begin
                        state_d = StZero;
                    end
                end
            end
            StZero:     state_d = StDone;
            StFetch:    state_d = StWaitLoad;
            StWaitLoad: begin
                if (load) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit && (len_q == '0)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_en && hold_tc) begin
                    cs_d    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        // Every load consumes one word and starts the prefetch of the next one.
        if (load) begin
            len_d  = len_q - LEN_WIDTH'(1);
            addr_d = addr_q + ADDR_WIDTH'(1);
            req_d  = 1'b1;
            dc_d   = word_src[DcBit];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            next_word_q <= '0;
            req_q       <= 1'b0;
            cap_q       <= 1'b0;
            cs_q        <= 1'b1;
            dc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            next_word_q <= next_word_d;
            req_q       <= req_d;
            cap_q       <= cap_d;
            cs_q        <= cs_d;
            dc_q        <= dc_d;
        end
    end

    assign memAddr         = addr_q;
    assign parallelLoad    = load;
    assign parallelDataOut = load ? word_src[DATA_WIDTH-1:0] : '0;
    assign dc              = load ? word_src[DcBit] : dc_q;
    assign cs              = cs_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: scoreboard of expected loads plus
// protocol monitors for spacing, hold time, chip-select and dc behaviour.
module tb_spi_frame_sequencer;

    localparam int HoldEdges = 2;

    typedef struct packed {
        logic [9:0] addr;
        logic [8:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic [9:0] baseAddr;
    logic [9:0] xferLen;
    logic       sclkPosEdge = 1'b0;
    logic       sclkNegEdge = 1'b0;
    logic [8:0] memData = '0;
    logic [9:0] memAddr;
    logic       parallelLoad;
    logic [7:0] parallelDataOut;
    logic       cs;
    logic       dc;
    logic       busy;
    logic       done;

    logic [8:0] mem [1024];
    exp_t       sb [$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int sclk_div = 4;
    int ph = 0;

    spi_frame_sequencer u_dut (
        .clk             (clk),
        .resetN          (resetN),
        .start           (start),
        .baseAddr        (baseAddr),
        .xferLen         (xferLen),
        .sclkPosEdge     (sclkPosEdge),
        .sclkNegEdge     (sclkNegEdge),
        .memData         (memData),
        .memAddr         (memAddr),
        .parallelLoad    (parallelLoad),
        .parallelDataOut (parallelDataOut),
        .cs              (cs),
        .dc              (dc),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory.
    always @(posedge clk) memData <= mem[memAddr];

    // Serial-clock strobe generator: one posedge and one negedge strobe per sclk_div clocks.
    always @(posedge clk) begin
        ph          <= (ph + 1 >= sclk_div) ? 0 : ph + 1;
        sclkPosEdge <= (ph == 0);
        sclkNegEdge <= (ph == sclk_div / 2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each load and checks protocol timing.
    initial begin : monitor
        int   nsl;
        int   pos_after;
        bit   first_load;
        logic prev_cs;
        logic prev_dc;
        exp_t e;
        nsl = 0;
        pos_after = 0;
        first_load = 1'b1;
        prev_cs = 1'b1;
        prev_dc = 1'b0;
        forever begin
            @(negedge clk);
            if (resetN !== 1'b1) begin
                nsl = 0;
                pos_after = 0;
                first_load = 1'b1;
                prev_cs = cs;
                prev_dc = dc;
            end else begin
                if (parallelLoad) begin
                    check_eq("load_with_neg", sclkNegEdge, 1);
                    check_eq("cs_low_at_load", cs, 0);
                    check_eq("busy_at_load", busy, 1);
                    if (!first_load) check_eq("load_spacing", nsl + 1, 8);
                    first_load = 1'b0;
                    nsl = 0;
                    pos_after = 0;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("load_addr", memAddr, e.addr);
                        check_eq("load_data", parallelDataOut, e.word[7:0]);
                        check_eq("load_dc", dc, e.word[8]);
                    end else begin
                        check_eq("sb_avail", sb.size(), 1);
                    end
                    load_cnt++;
                end else if (sclkNegEdge && nsl < 8) begin
                    nsl++;
                end
                if (sclkPosEdge && nsl >= 8) pos_after++;
                if (dc !== prev_dc) check_eq("dc_only_on_load", parallelLoad, 1);
                if (!prev_cs && cs) begin
                    check_eq("hold_negs", nsl, 8);
                    check_eq("hold_pos", pos_after, HoldEdges);
                end
                if (prev_cs && !cs) begin
                    first_load = 1'b1;
                    nsl = 0;
                    pos_after = 0;
                end
                if (done) begin
                    done_cnt++;
                    check_eq("busy_at_done", busy, 1);
                    check_eq("cs_at_done", cs, 1);
                    check_eq("sb_empty_at_done", sb.size(), 0);
                end
                prev_cs = cs;
                prev_dc = dc;
            end
        end
    end

    // Pulse start for one cycle; optionally record the expected words.
    task automatic start_xfer(input logic [9:0] base, input logic [9:0] len, input bit push);
        logic [9:0] a;
        if (push) begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + 10'(i);
                sb.push_back('{addr: a, word: mem[a]});
            end
        end
        start = 1'b1;
        baseAddr = base;
        xferLen = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq("single_done", done_cnt - d0, 1);
        check_eq("cs_idle", cs, 1);
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic wait_loads(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (load_cnt >= target) break;
        end
        #1;
        check_eq("load_seen", load_cnt >= target, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int d0;
        int l0;
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i * 37 + 5);
        mem[10'h010] = 9'h1A5;
        mem[10'h020] = 9'h03C;
        mem[10'h021] = 9'h181;
        mem[10'h022] = 9'h1FF;
        mem[10'h040] = 9'h1C3;
        mem[10'h3FE] = 9'h011;
        mem[10'h3FF] = 9'h122;
        mem[10'h000] = 9'h033;
        mem[10'h001] = 9'h144;

        resetN = 1'b0;
        start = 1'b0;
        baseAddr = '0;
        xferLen = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", cs, 1);
        check_eq("rst_dc", dc, 0);
        check_eq("rst_pload", parallelLoad, 0);
        check_eq("rst_pdata", parallelDataOut, 0);
        check_eq("rst_addr", memAddr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word.
        start_xfer(10'h010, 10'd1, 1'b1);
        check_eq("busy_after_start", busy, 1);
        check_eq("cs_after_start", cs, 0);
        wait_done(2000);

        // Zero length: busy next cycle, done the cycle after, no cs activity.
        l0 = load_cnt;
        start_xfer(10'h123, 10'd0, 1'b0);
        check_eq("zero_busy", busy, 1);
        check_eq("zero_done_early", done, 0);
        check_eq("zero_cs1", cs, 1);
        @(posedge clk);
        #1;
        check_eq("zero_done", done, 1);
        check_eq("zero_cs2", cs, 1);
        @(posedge clk);
        #1;
        check_eq("zero_done_gone", done, 0);
        check_eq("zero_no_load", load_cnt - l0, 0);

        // Second start mid-transfer must be ignored.
        l0 = load_cnt;
        start_xfer(10'h100, 10'd4, 1'b1);
        wait_loads(l0 + 2, 2000);
        start_xfer(10'h200, 10'd2, 1'b0);
        wait_done(4000);

        // Asynchronous abort during SHIFT.
        l0 = load_cnt;
        start_xfer(10'h040, 10'd3, 1'b1);
        wait_loads(l0 + 1, 2000);
        repeat (5) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check_eq("abort_cs", cs, 1);
        check_eq("abort_dc", dc, 0);
        check_eq("abort_pload", parallelLoad, 0);
        check_eq("abort_pdata", parallelDataOut, 0);
        check_eq("abort_addr", memAddr, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("no_done_on_abort", done_cnt - d0, 0);
        check_eq("idle_after_abort", busy, 0);

        // Back-to-back words with the fastest serial clock.
        sclk_div = 2;
        repeat (4) @(posedge clk);
        #1;
        l0 = load_cnt;
        start_xfer(10'h020, 10'd3, 1'b1);
        wait_done(2000);
        check_eq("b2b_loads", load_cnt - l0, 3);

        // Address wrap.
        sclk_div = 4;
        repeat (4) @(posedge clk);
        #1;
        l0 = load_cnt;
        start_xfer(10'h3FE, 10'd4, 1'b1);
        wait_done(4000);
        check_eq("wrap_loads", load_cnt - l0, 4);
        check_eq("wrap_final_addr", memAddr, 10'h002);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
